// File: rtl/s_axi4l_wr_arbiter.sv
// s_axi4l_wr_arbiter
//   Two requesters share the single register-file write port. These are the
//   AXI4-Lite write channel (bus) and an internal hardware update port (hw).
//   Bus writes cannot be stalled, so they are queued in a small FIFO. Hw writes
//   use a valid/ready handshake. A two-way round-robin arbiter loads a
//   registered output stage, and that stage holds each write until the
//   register file accepts it.
//
// Handshake semantics:
//   - A transfer on a valid/ready pair happens on a rising edge where both
//     valid and ready are 1.
//   - A valid source keeps its payload stable until that edge.
//   - i_bus_wvalid is the one exception. It is a fire-and-forget pulse with no
//     ready signal.
//
// Ports:
//   i_axi_clock, i_axi_aresetn           clock, async active-low reset
//   i_bus_waddr/wdata/wvalid             bus write pulse into the FIFO
//   o_bus_full, o_bus_ovf                FIFO full (registered), dropped-write pulse
//   i_hw_waddr/wdata/wvalid, o_hw_wready hw update request / accept
//   o_rf_waddr/wdata/wvalid, i_rf_wready register-file write port
//   o_rf_src                             source of held write: 0 = bus, 1 = hw
module s_axi4l_wr_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_axi_clock,
  input  logic                  i_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] i_bus_waddr,
  input  logic [DATA_WIDTH-1:0] i_bus_wdata,
  input  logic                  i_bus_wvalid,
  output logic                  o_bus_full,
  output logic                  o_bus_ovf,
  input  logic [ADDR_WIDTH-1:0] i_hw_waddr,
  input  logic [DATA_WIDTH-1:0] i_hw_wdata,
  input  logic                  i_hw_wvalid,
  output logic                  o_hw_wready,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_rf_wvalid,
  input  logic                  i_rf_wready,
  output logic                  o_rf_src
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Round-robin state: which source wins when both are pending.
  typedef enum logic {PRIO_BUS = 1'b0, PRIO_HW = 1'b1} prio_e;

  prio_e                 prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, ovf_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  rf_wvalid_q, rf_wvalid_d;
  logic                  rf_src_q, rf_src_d;

  logic stage_free, bus_req, grant_bus, grant_hw, push, pop, drop;

  always_comb begin
    stage_free = !rf_wvalid_q || i_rf_wready;
    bus_req    = (count_q != '0);
    grant_bus  = 1'b0;
    grant_hw   = 1'b0;
    if (stage_free) begin
      if (bus_req && (!i_hw_wvalid || prio_q == PRIO_BUS)) grant_bus = 1'b1;
      else if (i_hw_wvalid)                                 grant_hw  = 1'b1;
    end
    pop  = grant_bus;
    // A pop in the same cycle makes room, so a full FIFO can still take a push.
    push = i_bus_wvalid && ((count_q != DEPTH_C) || pop);
    drop = i_bus_wvalid && (count_q == DEPTH_C) && !pop;
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    prio_d = prio_q;
    if (grant_bus)     prio_d = PRIO_HW;
    else if (grant_hw) prio_d = PRIO_BUS;

    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_wvalid_d = rf_wvalid_q;
    rf_src_d    = rf_src_q;
    if (grant_bus) begin
      rf_waddr_d  = fifo_addr_q[rd_ptr_q];
      rf_wdata_d  = fifo_data_q[rd_ptr_q];
      rf_wvalid_d = 1'b1;
      rf_src_d    = 1'b0;
    end else if (grant_hw) begin
      rf_waddr_d  = i_hw_waddr;
      rf_wdata_d  = i_hw_wdata;
      rf_wvalid_d = 1'b1;
      rf_src_d    = 1'b1;
    end else if (stage_free) begin
      rf_wvalid_d = 1'b0;
    end
  end

  // FIFO storage carries no reset; the count and pointers define validity.
  always_ff @(posedge i_axi_clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_bus_waddr;
      fifo_data_q[wr_ptr_q] <= i_bus_wdata;
    end
  end

  always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      prio_q      <= PRIO_BUS;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rf_wvalid_q <= 1'b0;
      rf_src_q    <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_C);
      ovf_q       <= drop;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_wvalid_q <= rf_wvalid_d;
      rf_src_q    <= rf_src_d;
    end
  end

  assign o_bus_full  = full_q;
  assign o_bus_ovf   = ovf_q;
  assign o_hw_wready = grant_hw;
  assign o_rf_waddr  = rf_waddr_q;
  assign o_rf_wdata  = rf_wdata_q;
  assign o_rf_wvalid = rf_wvalid_q;
  assign o_rf_src    = rf_src_q;

endmodule

// File: tb/tb_s_axi4l_wr_arbiter.sv
// Directed bench for s_axi4l_wr_arbiter. Expected writes {src, addr, data}
// are queued as stimulus is driven; a negedge monitor pops and compares each
// write the register file accepts.
module tb_s_axi4l_wr_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int W  = 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] bus_waddr, hw_waddr, rf_waddr;
  logic [DW-1:0] bus_wdata, hw_wdata, rf_wdata;
  logic bus_wvalid, bus_full, bus_ovf, hw_wvalid, hw_wready;
  logic rf_wvalid, rf_wready, rf_src;

  s_axi4l_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .i_axi_clock  (clk),
    .i_axi_aresetn(rst_n),
    .i_bus_waddr  (bus_waddr),
    .i_bus_wdata  (bus_wdata),
    .i_bus_wvalid (bus_wvalid),
    .o_bus_full   (bus_full),
    .o_bus_ovf    (bus_ovf),
    .i_hw_waddr   (hw_waddr),
    .i_hw_wdata   (hw_wdata),
    .i_hw_wvalid  (hw_wvalid),
    .o_hw_wready  (hw_wready),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_rf_wvalid  (rf_wvalid),
    .i_rf_wready  (rf_wready),
    .o_rf_src     (rf_src)
  );

  // ---------------- scoreboard ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_wvalid && rf_wready) begin
      n_asserts++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed %0h expected none",
               {rf_src, rf_waddr, rf_wdata});
      end
      if (exp_q.size() > 0) check("rf_write", 64'({rf_src, rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_out);
    bus_waddr  = a;
    bus_wdata  = d;
    bus_wvalid = 1'b1;
    if (expect_out) exp_q.push_back({1'b0, a, d});
  endtask

  task automatic drive_hw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hw_waddr  = a;
    hw_wdata  = d;
    hw_wvalid = 1'b1;
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    step();
    @(negedge clk);
    check({tag, "_idle"}, 64'(rf_wvalid), 64'd0);
    step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_waddr = '0; bus_wdata = '0; bus_wvalid = 1'b0;
    hw_waddr  = '0; hw_wdata  = '0; hw_wvalid  = 1'b0;
    rf_wready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wvalid", 64'(rf_wvalid), 64'd0);
    check("rst_waddr",  64'(rf_waddr),  64'd0);
    check("rst_wdata",  64'(rf_wdata),  64'd0);
    check("rst_src",    64'(rf_src),    64'd0);
    check("rst_full",   64'(bus_full),  64'd0);
    check("rst_ovf",    64'(bus_ovf),   64'd0);
    check("rst_wready", 64'(hw_wready), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single bus write: valid exactly in N+2
    drive_bus(8'h04, 32'hDEADBEEF, 1'b1);
    @(negedge clk); check("lat_n", 64'(rf_wvalid), 64'd0);
    step(); bus_wvalid = 1'b0;
    @(negedge clk); check("lat_n1", 64'(rf_wvalid), 64'd0);
    step();
    @(negedge clk);
    check("lat_n2_valid", 64'(rf_wvalid), 64'd1);
    check("lat_n2_addr",  64'(rf_waddr),  64'h04);
    check("lat_n2_data",  64'(rf_wdata),  64'hDEADBEEF);
    check("lat_n2_src",   64'(rf_src),    64'd0);
    step();
    @(negedge clk); check("lat_n3", 64'(rf_wvalid), 64'd0);
    wait_drain("single_drain");

    // Stall hold with a second hw request waiting
    rf_wready = 1'b0;
    drive_hw(8'h20, 32'h55);
    @(negedge clk); check("stall_grant", 64'(hw_wready), 64'd1);
    step();
    drive_hw(8'h24, 32'h66);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid",  64'(rf_wvalid), 64'd1);
      check("stall_addr",   64'(rf_waddr),  64'h20);
      check("stall_data",   64'(rf_wdata),  64'h55);
      check("stall_src",    64'(rf_src),    64'd1);
      check("stall_wready", 64'(hw_wready), 64'd0);
      step();
    end
    rf_wready = 1'b1;
    @(negedge clk); check("stall_release_wready", 64'(hw_wready), 64'd1);
    step();
    hw_wvalid = 1'b0;
    wait_drain("stall_drain");

    // Contention: expected order 0x10, 0x80, 0x14, 0x84, 0x18
    pulse_reset();
    bus_waddr = 8'h10; bus_wdata = 32'h1000_0010; bus_wvalid = 1'b1;
    exp_q.push_back({1'b0, 8'h10, 32'h1000_0010});
    exp_q.push_back({1'b1, 8'h80, 32'h8000_0080});
    exp_q.push_back({1'b0, 8'h14, 32'h1000_0014});
    exp_q.push_back({1'b1, 8'h84, 32'h8000_0084});
    exp_q.push_back({1'b0, 8'h18, 32'h1000_0018});
    step();
    bus_waddr = 8'h14; bus_wdata = 32'h1000_0014;
    hw_waddr = 8'h80; hw_wdata = 32'h8000_0080; hw_wvalid = 1'b1;
    @(negedge clk); check("cont_c1_wready", 64'(hw_wready), 64'd0);
    step();
    bus_waddr = 8'h18; bus_wdata = 32'h1000_0018;
    @(negedge clk); check("cont_c2_wready", 64'(hw_wready), 64'd1);
    step();
    bus_wvalid = 1'b0;
    hw_waddr = 8'h84; hw_wdata = 32'h8000_0084;
    @(negedge clk); check("cont_c3_wready", 64'(hw_wready), 64'd0);
    step();
    @(negedge clk); check("cont_c4_wready", 64'(hw_wready), 64'd1);
    step();
    hw_wvalid = 1'b0;
    wait_drain("cont_drain");

    // Reset in the middle of a stall with queued bus writes
    rf_wready = 1'b0;
    drive_bus(8'h40, 32'h40, 1'b0); step();
    drive_bus(8'h44, 32'h44, 1'b0); step();
    drive_bus(8'h48, 32'h48, 1'b0); step();
    bus_wvalid = 1'b0;
    @(negedge clk); check("rstall_valid", 64'(rf_wvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstall_async_valid", 64'(rf_wvalid), 64'd0);
    check("rstall_async_full",  64'(bus_full),  64'd0);
    step();
    rst_n = 1'b1;
    rf_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("rstall_no_stale", 64'(rf_wvalid), 64'd0);
      step();
    end
    drive_bus(8'h30, 32'h3030_3030, 1'b1);
    step();
    bus_wvalid = 1'b0;
    drive_hw(8'h90, 32'h9090_9090);
    @(negedge clk); check("prio_restart_bus", 64'(hw_wready), 64'd0);
    step();
    @(negedge clk); check("prio_restart_hw", 64'(hw_wready), 64'd1);
    step();
    hw_wvalid = 1'b0;
    wait_drain("rstall_drain");

    // Overflow with the output stage held by a hw write
    rf_wready = 1'b0;
    drive_hw(8'hA0, 32'hA0A0);
    @(negedge clk); check("ovf_hw_grant", 64'(hw_wready), 64'd1);
    step();
    hw_wvalid = 1'b0;
    drive_bus(8'hB1, 32'hB1, 1'b1); step();
    drive_bus(8'hB2, 32'hB2, 1'b1); step();
    drive_bus(8'hB3, 32'hB3, 1'b1); step();
    drive_bus(8'hB4, 32'hB4, 1'b1);
    @(negedge clk); check("ovf_full_before4", 64'(bus_full), 64'd0);
    step();
    drive_bus(8'hB5, 32'hB5, 1'b0);
    @(negedge clk);
    check("ovf_full_after4", 64'(bus_full), 64'd1);
    check("ovf_none_yet",    64'(bus_ovf),  64'd0);
    step();
    bus_wvalid = 1'b0;
    @(negedge clk);
    check("ovf_pulse", 64'(bus_ovf),  64'd1);
    check("ovf_full",  64'(bus_full), 64'd1);
    step();

    // Full FIFO: release ready together with a bus pulse
    rf_wready = 1'b1;
    drive_bus(8'hB6, 32'hB6, 1'b1);
    @(negedge clk); check("ovf_pulse_once", 64'(bus_ovf), 64'd0);
    step();
    bus_wvalid = 1'b0;
    @(negedge clk);
    check("pushpop_full", 64'(bus_full), 64'd1);
    check("pushpop_ovf",  64'(bus_ovf),  64'd0);
    step();
    @(negedge clk); check("pushpop_drain_full", 64'(bus_full), 64'd0);
    wait_drain("ovf_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/s_axi4l_wr_arbiter.md
# s_axi4l_wr_arbiter

Shares the single register-file write port between two requesters: the AXI4-Lite write channel's register-file write output and an internal hardware update port. The bus side has no backpressure, so its writes enter a small FIFO. The hardware side uses a valid/ready handshake. A two-way round-robin arbiter loads a registered output stage that holds each write until the register file accepts it.

## Interface
Parameters:
- ADDR_WIDTH, 8, register address width
- DATA_WIDTH, 32, register data width
- FIFO_DEPTH, 4, bus-side FIFO entries; power of two, at least 2

Ports:
- i_axi_clock  in  1  clock; all logic on the rising edge
- i_axi_aresetn  in  1  reset; asynchronous assert, active-low; one clock, reset asynchronous active-low
- i_bus_waddr  in  ADDR_WIDTH  bus write address
- i_bus_wdata  in  DATA_WIDTH  bus write data
- i_bus_wvalid  in  1  one-cycle pulse per bus write; cannot be stalled
- o_bus_full  out  1  FIFO holds FIFO_DEPTH entries
- o_bus_ovf  out  1  one-cycle pulse when a bus write is dropped
- i_hw_waddr  in  ADDR_WIDTH  hardware update address
- i_hw_wdata  in  DATA_WIDTH  hardware update data
- i_hw_wvalid  in  1  hardware request; held until accepted
- o_hw_wready  out  1  hardware request accepted this cycle
- o_rf_waddr  out  ADDR_WIDTH  register-file write address
- o_rf_wdata  out  DATA_WIDTH  register-file write data
- o_rf_wvalid  out  1  output write valid
- i_rf_wready  in  1  register file accepts the write
- o_rf_src  out  1  source of the current output write: 0 = bus, 1 = hw

## Operation
FIFO:
- A push happens when i_bus_wvalid=1 and either count<FIFO_DEPTH or a pop occurs in the same cycle.
- A push with count==FIFO_DEPTH and no pop is discarded and raises o_bus_ovf for one cycle.
- Pointers wrap modulo FIFO_DEPTH.
- The count register is log2(FIFO_DEPTH)+1 bits wide.

Output stage:
- The output stage is free when o_rf_wvalid=0 or (o_rf_wvalid & i_rf_wready).
- The stage loads only when it is free and at least one requester is pending.

Arbitration:
- Requesters are bus (FIFO non-empty, head entry) and hw (i_hw_wvalid).
- If only one requester is pending, it wins.
- If both are pending, the requester with priority wins.
- After any grant, priority passes to the other source.
- Priority after reset is bus.

Grant actions:
- A bus grant pops the FIFO head into the output stage and sets o_rf_src=0.
- A hw grant asserts o_hw_wready combinationally in the same cycle, loads i_hw_waddr/wdata and sets o_rf_src=1.
- o_hw_wready=1 only in a cycle where hw is granted; it is never asserted while the output stage is occupied and stalled.

Reset:
- Reset at any time empties the FIFO and discards any held output and in-flight writes.
- Reset values: o_rf_wvalid=0, o_rf_waddr=0, o_rf_wdata=0, o_rf_src=0, o_bus_full=0, o_bus_ovf=0, o_hw_wready=0; priority set to bus.

## Timing
Latency:
- Bus pulse in cycle N, output free, no contention: o_rf_wvalid=1 in cycle N+2. The FIFO write lands at edge N and the output load at edge N+1; there is no FIFO bypass.
- hw valid in cycle N, output free, hw granted: o_hw_wready=1 in N, o_rf_wvalid=1 in N+1.

Throughput:
- With i_rf_wready held at 1, one write per cycle.
- Under sustained contention, grants alternate bus/hw/bus/hw.

Stall:
- While i_rf_wready=0, o_rf_waddr, o_rf_wdata, o_rf_src and o_rf_wvalid stay stable.
- The stage loads the next write in the same cycle the held write is accepted, so back-to-back valid cycles have no bubble.

Status outputs:
- o_bus_full is registered and reflects count after the edge.
- o_bus_ovf is registered and asserts the cycle after the dropped pulse.

Simultaneous push and pop on a full FIFO:
- Count stays at FIFO_DEPTH.
- o_bus_full stays 1.
- No overflow is flagged.

## Test plan
- Reset mid-stall: 3 bus writes queued, i_rf_wready=0, deassert i_axi_aresetn -> o_rf_wvalid=0 immediately. After release, no stale write appears; priority restarts at bus.
- Single bus write: addr 0x04, data 0xDEADBEEF pulsed in cycle N, i_rf_wready=1 -> o_rf_wvalid=1 in N+2 only, addr 0x04, data 0xDEADBEEF, o_rf_src=0.
- Contention: bus writes 0x10/0x14/0x18 and hw holding 0x80/0x84 continuously, ready=1 -> output order 0x10, 0x80, 0x14, 0x84, 0x18.
- Stall hold: hw write 0x20/0x55 accepted, i_rf_wready=0 for 5 cycles -> outputs stable all 5 cycles, o_hw_wready=0 for a second hw request until the stall releases.
- Overflow: FIFO_DEPTH=4, i_rf_wready=0, 5 bus pulses -> o_bus_full=1 after the 4th, o_bus_ovf pulses once for the 5th. After release, exactly 4 writes emerge in order.
- Full push+pop: FIFO full, release i_rf_wready with a simultaneous bus pulse -> pulse accepted, no o_bus_ovf, count remains 4.
